// File: rtl/flex_counter_ud.sv
// Up/down counter with start/rollover bounds, parallel load, wrap or saturate, terminal pulse; FLEX_CNT_WRAP_CNT_EN adds wrap_count.
// Latency: one cycle; every output is registered.
// Backpressure: none; count_enable is a per-cycle strobe and the counter never stalls its driver.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     up_down,
    input  logic                     sat_mode,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  start_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     terminal_pulse
`ifdef FLEX_CNT_WRAP_CNT_EN
    ,
    output logic [NUM_WRAP_BITS-1:0] wrap_count
`endif
);

    if (NUM_CNT_BITS < 1 || NUM_WRAP_BITS < 1) begin : g_bad_width
        $error("flex_counter_ud: counter widths must be at least 1");
    end

    logic [NUM_CNT_BITS-1:0] next_count;
    logic [NUM_CNT_BITS-1:0] term_val;
    logic [NUM_CNT_BITS-1:0] wrap_tgt;
    logic                    term_hit;
    logic                    pulse_next;
    logic                    flag_next;
    logic                    wrap_evt;

    // The terminal value depends on direction: top bound going up, bottom bound going down.
    assign term_val = up_down ? rollover_val : start_val;
    assign wrap_tgt = up_down ? start_val    : rollover_val;
    assign term_hit = (count_out == term_val);

    always_comb begin
        next_count = count_out;
        pulse_next = 1'b0;
        wrap_evt   = 1'b0;
        if (clear) begin
            next_count = start_val;
        end else if (load) begin
            next_count = load_val;
        end else if (count_enable) begin
            if (term_hit) begin
                pulse_next = 1'b1;
                wrap_evt   = ~sat_mode;
                next_count = sat_mode ? count_out : wrap_tgt;
            end else if (up_down) begin
                next_count = count_out + 1'b1;
            end else begin
                next_count = count_out - 1'b1;
            end
        end
        flag_next = (next_count == term_val) && !clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            terminal_pulse <= 1'b0;
        end else begin
            count_out      <= next_count;
            rollover_flag  <= flag_next;
            terminal_pulse <= pulse_next;
        end
    end

`ifdef FLEX_CNT_WRAP_CNT_EN
    // Only wrap-mode terminal events count; load leaves the tally alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_count <= '0;
        end else if (clear) begin
            wrap_count <= '0;
        end else if (wrap_evt) begin
            wrap_count <= wrap_count + 1'b1;
        end
    end
`else
    logic unused_wrap_evt;
    assign unused_wrap_evt = wrap_evt;
`endif

endmodule
